// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and sizes for the register-file writeback arbiter and its users.
// Holds the writeback request layout and the round-robin priority encoding.
package regfile_wb_arbiter_pkg;

   localparam int REG_IDX_W = 5;
   localparam int NUM_REGS  = 32;
   localparam int DATA_W    = 32;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef struct packed {
      reg_idx_t          rd;
      logic [DATA_W-1:0] data;
   } wb_req_t;

   typedef enum logic {
      PRIO_A = 1'b0,
      PRIO_B = 1'b1
   } prio_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: the requester that was not granted most
// recently wins a tie, so neither side waits for more than one grant.
module rr_arb2
   import regfile_wb_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rstn,
   input  logic req_a_i,
   input  logic req_b_i,
   output logic gnt_a_o,
   output logic gnt_b_o
);

   prio_e prio_q, prio_d;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         prio_q <= PRIO_A;
      end else begin
         prio_q <= prio_d;
      end
   end

   // Grants are suppressed while reset is asserted so in-flight requests drop.
   always_comb begin
      gnt_a_o = 1'b0;
      gnt_b_o = 1'b0;
      prio_d  = prio_q;
      if (rstn) begin
         gnt_a_o = req_a_i && (!req_b_i || (prio_q == PRIO_A));
         gnt_b_o = req_b_i && (!req_a_i || (prio_q == PRIO_B));
      end
      if (gnt_a_o) begin
         prio_d = PRIO_B;
      end else if (gnt_b_o) begin
         prio_d = PRIO_A;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges the ALU and load writeback paths onto one registered register-file
// write port and tracks pending destination registers for hazard detection.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int BITS = 32
)(
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 a_valid,
   input  logic [REG_IDX_W-1:0] a_rd,
   input  logic [BITS-1:0]      a_data,
   output logic                 a_ready,
   input  logic                 b_valid,
   input  logic [REG_IDX_W-1:0] b_rd,
   input  logic [BITS-1:0]      b_data,
   output logic                 b_ready,
   output logic                 wr_en,
   output logic [REG_IDX_W-1:0] wr_rd,
   output logic [BITS-1:0]      wr_data,
   input  logic                 iss_valid,
   input  logic [REG_IDX_W-1:0] iss_rd,
   input  logic [REG_IDX_W-1:0] chk_rs,
   input  logic [REG_IDX_W-1:0] chk_rt,
   output logic                 hazard,
   output logic [NUM_REGS-1:0]  busy_mask
);

   logic                 gntA, gntB;
   reg_idx_t             selRd;
   logic [BITS-1:0]      selData;
   logic                 wrEn_q, wrEn_d;
   reg_idx_t             wrRd_q, wrRd_d;
   logic [BITS-1:0]      wrData_q, wrData_d;
   logic [NUM_REGS-1:0]  busy_q, busy_d;

   rr_arb2 u_arb (
      .clk     (clk),
      .rstn    (rstn),
      .req_a_i (a_valid),
      .req_b_i (b_valid),
      .gnt_a_o (gntA),
      .gnt_b_o (gntB)
   );

   assign a_ready = gntA;
   assign b_ready = gntB;

   // Writes to r0 still handshake but never reach the register file.
   always_comb begin
      selRd    = gntB ? b_rd : a_rd;
      selData  = gntB ? b_data : a_data;
      wrEn_d   = (gntA || gntB) && (selRd != '0);
      wrRd_d   = wrRd_q;
      wrData_d = wrData_q;
      if (wrEn_d) begin
         wrRd_d   = selRd;
         wrData_d = selData;
      end
   end

   // Issue sets are applied after retire clears so a same-register collision
   // leaves the register pending.
   always_comb begin
      busy_d = busy_q;
      if (wrEn_q) begin
         busy_d[wrRd_q] = 1'b0;
      end
      if (iss_valid && (iss_rd != '0)) begin
         busy_d[iss_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wrEn_q   <= 1'b0;
         wrRd_q   <= '0;
         wrData_q <= '0;
         busy_q   <= '0;
      end else begin
         wrEn_q   <= wrEn_d;
         wrRd_q   <= wrRd_d;
         wrData_q <= wrData_d;
         busy_q   <= busy_d;
      end
   end

   assign wr_en     = wrEn_q;
   assign wr_rd     = wrRd_q;
   assign wr_data   = wrData_q;
   assign busy_mask = busy_q;
   assign hazard    = rstn && (busy_q[chk_rs] || busy_q[chk_rt]);

endmodule
